hit_miss_pipe_ctrl: RTL and testbench
=====================================

# hit_miss_pipe_ctrl

Sequencing and arbitration controller for the fixed-latency lookup pipeline in the hit/miss detection path. It grants one of two requesters (port 0: normal descriptors, port 1: flush/maintenance descriptors) per cycle with round-robin fairness and pushes the winner into an internal gated shift register of `Depth` stages. It generates the global shift enable from downstream backpressure, tracks occupancy, and supports a drain request that quiesces the pipeline before flush or reconfiguration.

## Interface
- `Depth`, default 3: lookup latency in stages; 0 gives a combinational pass-through.
- `dtype`, default `logic`: payload type carried alongside each request.
- `CntWidth`, default `$clog2(Depth+1)`: width of the occupancy counter. Derived; do not override.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active-low.
- `req_valid_i` in 2: request valid, one bit per requester.
- `req_data_i` in 2×`dtype`: request payload per requester.
- `req_ready_o` out 2: grant and accept, per requester.
- `drain_i` in 1: stop accepting new requests; level-sensitive.
- `out_valid_o` out 1: pipeline output valid.
- `out_data_o` out `dtype`: payload at pipeline output.
- `out_id_o` out 1: requester index of the output entry.
- `out_ready_i` in 1: downstream accept.
- `count_o` out `CntWidth`: entries in flight, including the output slot.
- `idle_o` out 1: `count_o == 0`.
- `drained_o` out 1: `drain_i & idle_o`.

## Operation
- Shift enable: `shift_en = ~out_valid_o | out_ready_i`. The whole pipe advances or stalls together. Empty stages shift as bubbles; bubbles are not compressed.
- Arbitration runs only when `shift_en & ~drain_i`.
  - If exactly one `req_valid_i` bit is set, that requester is granted.
  - If both are set, the grant goes to `rr_q`.
  - When no arbitration runs, `req_ready_o = 2'b00`.
- Requesters are decoupled: a valid request may be withdrawn only after it is accepted. `req_ready_o` depends combinationally on the other requester's valid.
- Round-robin pointer `rr_q` (1 bit, reset 0) toggles to `~granted_id` only on a cycle where both requesters were valid and one was granted. In all other cycles it holds.
- Accepted entries `{id, data}` enter stage 0 with valid=1. On a shift cycle with no grant, a valid=0 bubble enters instead.
- Occupancy counter `cnt_q`:
  - +1 on accept (`|(req_valid_i & req_ready_o)`).
  - −1 on output handshake (`out_valid_o & out_ready_i`).
  - Both in the same cycle: unchanged.
  - It cannot exceed `Depth` because accept requires `shift_en`. The RTL asserts `cnt_q <= Depth` and asserts no decrement at 0.
- Drain: `drain_i` blocks new grants immediately, in the same cycle. In-flight entries keep flowing. `drained_o` rises once `cnt_q == 0`. Deasserting `drain_i` resumes arbitration in that same cycle.
- `Depth == 0`:
  - `out_valid_o` = OR of the granted valid.
  - `req_ready_o` follows `out_ready_i` through the arbiter.
  - The counter is unused, tied to 0, so `idle_o = 1`.
- Reset values: `out_valid_o=0`, `out_data_o='0`, `out_id_o=0`, `count_o=0`, `idle_o=1`, `drained_o=drain_i`, `rr_q=0`. `req_ready_o` follows the reset state (empty pipe, so `shift_en=1`).
- Reset asserted mid-operation discards all in-flight entries asynchronously; no output handshake occurs.

## Timing
- Latency: an accept in cycle N appears on `out_valid_o` in cycle N+`Depth`, absent stalls.
- Each stall cycle (`out_valid_o & ~out_ready_i`) freezes all stages and adds exactly one cycle to every in-flight entry.
- Throughput is one entry per cycle while `out_ready_i` stays high.
- `count_o`, `idle_o` and `drained_o` reflect registered state: they update the cycle after the event.
- The payload registers are gated with `shift_en & valid`, so bubble stages hold stale data. `out_data_o` is meaningful only when `out_valid_o` is high.

## Structure
- The pipeline is one instance of `shift_reg_gated_with_enable`, with:
  - `dtype` = the local packed struct `{logic id; dtype data}`;
  - `shift_en_i` driven by the computed `shift_en`;
  - `waiting_valid_o` unused.
- The arbiter, counter and drain logic are inline. No separate arbiter sub-module is needed for two requesters.
- No shared-package additions: the entry struct depends on the `dtype` parameter, so it stays local. `CntWidth` is a localparam.

## Test plan
- Single request:
  - Stimulus: `Depth=3`, port 0 sends payload 0xA5 at cycle 5, `out_ready_i=1`.
  - Required: `out_valid_o` at cycle 8 with data 0xA5 and id 0; `count_o` is 1 during cycles 6–8 and 0 from cycle 9.
- Fairness:
  - Stimulus: both ports valid continuously for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1 starting from reset; output ids arrive in the same order.
- Backpressure:
  - Stimulus: fill three entries, then hold `out_ready_i=0` for 4 cycles.
  - Required: `req_ready_o=00` during the stall, `count_o=3` held, output order preserved, each entry delayed by exactly 4 cycles.
- Simultaneous accept and retire:
  - Stimulus: steady stream with `out_ready_i=1`.
  - Required: `count_o` stays constant at 3.
- Drain:
  - Stimulus: assert `drain_i` with 2 entries in flight.
  - Required: no new grants; `drained_o` rises the cycle after the last output handshake; clearing `drain_i` produces a grant in that same cycle.
- Reset mid-flight:
  - Stimulus: pulse `rst_ni` low with 3 entries in flight.
  - Required: `out_valid_o=0`, `count_o=0` and `rr_q=0` immediately; none of the 3 entries ever appears at the output.

Source files
------------

// File: rtl/hit_miss_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hit_miss_pipe_ctrl_pkg
// Shared definitions for the hit/miss lookup pipeline controller.
//   NumReq    : number of requesters (port 0 normal, port 1 flush/maintenance)
//   req_vec_t : one bit per requester
//   req_id_e  : requester index
//   rr_grant  : two-way round-robin grant, one-hot result
// -----------------------------------------------------------------------------
package hit_miss_pipe_ctrl_pkg;

    localparam int unsigned NumReq = 2;

    typedef logic [NumReq-1:0] req_vec_t;

    typedef enum logic {
        REQ_NORMAL = 1'b0,
        REQ_FLUSH  = 1'b1
    } req_id_e;

    // A lone requester always wins; on contention the pointer decides.
    function automatic req_vec_t rr_grant(input req_vec_t valid, input logic rr);
        req_vec_t gnt;
        if (&valid) begin
            gnt = rr ? 2'b10 : 2'b01;
        end else begin
            gnt = valid;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/hit_miss_pipe_ctrl_shift_reg.sv
// -----------------------------------------------------------------------------
// shift_reg_gated_with_enable
// Fixed-latency valid/data shift register. All stages advance together when
// shift_en_i is high; data registers load only when the incoming stage is
// valid, so bubble stages keep stale payload.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   valid_i, data_i : entry presented to stage 0
//   shift_en_i      : global advance enable
//   valid_o, data_o : last stage (output slot)
//   waiting_valid_o : some stage holds a valid entry
// Depth == 0 is a combinational pass-through.
// -----------------------------------------------------------------------------
module shift_reg_gated_with_enable #(
    parameter int unsigned Depth = 3,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  dtype data_i,
    input  logic shift_en_i,
    output logic valid_o,
    output dtype data_o,
    output logic waiting_valid_o
);

    if (Depth == 0) begin : g_pass
        assign valid_o         = valid_i;
        assign data_o          = data_i;
        assign waiting_valid_o = 1'b0;
    end else begin : g_pipe
        logic [Depth-1:0] stage_valid;
        dtype             stage_data [Depth];

        for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
            logic in_valid;
            dtype in_data;
            logic valid_q;
            dtype data_q;

            if (gi == 0) begin : g_head
                assign in_valid = valid_i;
                assign in_data  = data_i;
            end else begin : g_body
                assign in_valid = stage_valid[gi-1];
                assign in_data  = stage_data[gi-1];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                end else if (shift_en_i) begin
                    valid_q <= in_valid;
                end
            end

            // Payload only moves with a valid entry; bubbles do not toggle it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_q <= '0;
                end else if (shift_en_i && in_valid) begin
                    data_q <= in_data;
                end
            end

            assign stage_valid[gi] = valid_q;
            assign stage_data[gi]  = data_q;
        end

        assign valid_o         = stage_valid[Depth-1];
        assign data_o          = stage_data[Depth-1];
        assign waiting_valid_o = |stage_valid;
    end

endmodule

// File: rtl/hit_miss_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// hit_miss_pipe_ctrl
// Two-requester round-robin arbiter feeding a fixed-latency lookup pipeline,
// with backpressure-derived shift enable, occupancy tracking and drain.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   req_valid_i / req_data_i  : per-requester request and payload
//   req_ready_o               : per-requester grant (accept this cycle)
//   drain_i                   : block new grants while held
//   out_valid_o / out_data_o  : pipeline output slot
//   out_id_o                  : requester index of the output entry
//   out_ready_i               : downstream accept
//   count_o                   : entries in flight, output slot included
//   idle_o / drained_o        : count_o == 0 / drain_i & idle_o
// -----------------------------------------------------------------------------
module hit_miss_pipe_ctrl
    import hit_miss_pipe_ctrl_pkg::*;
#(
    parameter int unsigned Depth    = 3,
    parameter type         dtype    = logic,
    // Derived from Depth; floored at 1 so Depth == 0 still has a legal port.
    parameter int unsigned CntWidth = (Depth == 0) ? 1 : $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_valid_i,
    input  dtype [NumReq-1:0]   req_data_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  logic                drain_i,
    output logic                out_valid_o,
    output dtype                out_data_o,
    output logic                out_id_o,
    input  logic                out_ready_i,
    output logic [CntWidth-1:0] count_o,
    output logic                idle_o,
    output logic                drained_o
);

    typedef struct packed {
        logic id;
        dtype data;
    } entry_t;

    logic          shift_en;
    logic          arb_en;
    req_vec_t      gnt;
    req_id_e       gnt_id;
    logic          accept;
    logic          retire;
    logic          rr_q, rr_d;
    entry_t        in_entry;
    entry_t        out_entry;
    logic          pipe_busy;
    logic [CntWidth-1:0] cnt_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign arb_en      = shift_en & ~drain_i;
    assign gnt         = arb_en ? rr_grant(req_valid_i, rr_q) : 2'b00;
    assign req_ready_o = gnt;
    assign accept      = |gnt;
    assign gnt_id      = gnt[1] ? REQ_FLUSH : REQ_NORMAL;

    // Pointer only moves when there was real contention.
    always_comb begin
        rr_d = rr_q;
        if ((&req_valid_i) && accept) begin
            rr_d = ~gnt_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline
    // ------------------------------------------------------------------
    assign in_entry.id   = gnt_id;
    assign in_entry.data = req_data_i[gnt_id];

    shift_reg_gated_with_enable #(
        .Depth (Depth),
        .dtype (entry_t)
    ) u_pipe (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .valid_i         (accept),
        .data_i          (in_entry),
        .shift_en_i      (shift_en),
        .valid_o         (out_valid_o),
        .data_o          (out_entry),
        .waiting_valid_o (pipe_busy)
    );

    assign out_data_o = out_entry.data;
    assign out_id_o   = out_entry.id;
    assign retire     = out_valid_o & out_ready_i;

    // ------------------------------------------------------------------
    // Shift enable and occupancy
    // ------------------------------------------------------------------
    if (Depth == 0) begin : g_zero
        // Output is the grant itself, so gate on downstream ready directly
        // to avoid a loop through out_valid_o.
        assign shift_en = out_ready_i;
        assign cnt_q    = '0;
    end else begin : g_cnt
        logic [CntWidth-1:0] cnt_d;

        assign shift_en = ~out_valid_o | out_ready_i;

        always_comb begin
            cnt_d = cnt_q;
            if (accept && !retire) begin
                cnt_d = cnt_q + CntWidth'(1);
            end else if (!accept && retire) begin
                cnt_d = cnt_q - CntWidth'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

`ifndef SYNTHESIS
        a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
            cnt_q <= CntWidth'(Depth));
        a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(retire && !accept && (cnt_q == '0)));
        a_empty_means_no_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (cnt_q == '0) |-> !pipe_busy);
`endif
    end

    assign count_o   = cnt_q;
    assign idle_o    = (cnt_q == '0);
    assign drained_o = drain_i & idle_o;

endmodule

// File: tb/tb_hit_miss_pipe_ctrl.sv
module tb_hit_miss_pipe_ctrl;

    localparam int DEPTH = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid;
    logic [1:0][7:0] req_data;
    logic [1:0]      req_ready;
    logic            drain;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_id;
    logic            out_ready;
    logic [1:0]      count;
    logic            idle;
    logic            drained;

    always #5 clk = ~clk;

    hit_miss_pipe_ctrl #(
        .Depth (DEPTH),
        .dtype (logic [7:0])
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .drain_i     (drain),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_ready_i (out_ready),
        .count_o     (count),
        .idle_o      (idle),
        .drained_o   (drained)
    );

    // Reference model: in-flight entries in order, each with the number of
    // pipeline advances it has seen. The head is visible once it has aged
    // DEPTH advances; a stall simply stops everybody from aging.
    typedef struct { bit id; bit [7:0] data; int age; } ent_t;
    typedef struct { bit id; bit [7:0] data; int cyc; } obs_t;

    ent_t q[$];
    obs_t out_obs[$];
    bit   gnt_obs[$];
    bit   rr_m = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit model_ov();
        return (q.size() > 0) && (q[0].age == DEPTH);
    endfunction

    function automatic logic [1:0] model_ready();
        bit sh;
        sh = !model_ov() || out_ready;
        if (!sh || drain) return 2'b00;
        if (req_valid == 2'b11) return rr_m ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    // One clock: compare everything at negedge+1, advance the model on the
    // edge, then retire accepted requests once safely past the edge.
    task automatic cycle();
        logic [1:0] er;
        bit         eov;
        bit         sh;
        ent_t       e;
        obs_t       o;
        #1;
        eov = model_ov();
        er  = model_ready();
        sh  = !eov || out_ready;
        check("req_ready", req_ready, er);
        check("out_valid", out_valid, eov);
        if (eov) begin
            check("out_data", out_data, q[0].data);
            check("out_id", out_id, q[0].id);
        end
        check("count", count, q.size());
        check("idle", idle, q.size() == 0);
        check("drained", drained, drain && (q.size() == 0));
        if (|req_ready) gnt_obs.push_back(req_ready[1]);
        if (out_valid && out_ready) begin
            o.id = out_id; o.data = out_data; o.cyc = cyc;
            out_obs.push_back(o);
        end
        @(posedge clk);
        if (eov && out_ready) void'(q.pop_front());
        if (sh) foreach (q[i]) q[i].age++;
        if (|er) begin
            e.id = er[1]; e.data = req_data[er[1]]; e.age = 1;
            q.push_back(e);
            if (req_valid == 2'b11) rr_m = ~er[1];
        end
        cyc++;
        @(negedge clk);
        req_valid = req_valid & ~er;
    endtask

    // Raise a request on any idle port with the given probability.
    task automatic gen(input int pct);
        for (int p = 0; p < 2; p++) begin
            if (!req_valid[p] && ($urandom_range(99) < pct)) begin
                req_valid[p] = 1'b1;
                req_data[p]  = 8'($urandom);
            end
        end
    endtask

    task automatic flush();
        drain = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (q.size() != 0 || req_valid != 2'b00); k++) cycle();
        #1;
        check("flush_idle", idle, 1);
        @(negedge clk);
    endtask

    initial begin
        int c;
        int hits;
        int first_drained;
        bit found;

        req_valid = 2'b00;
        req_data  = '0;
        drain     = 1'b0;
        out_ready = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_count", count, 0);
        check("rst_idle", idle, 1);
        check("rst_drained_lo", drained, 0);
        check("rst_ready", req_ready, 2'b00);
        drain = 1'b1;
        #1;
        check("rst_drained_hi", drained, 1);
        drain = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- single request ----------------
        cycle();
        cycle();
        req_valid = 2'b01;
        req_data[0] = 8'hA5;
        cycle();
        cycle();
        cycle();
        #1;
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        check("single_id", out_id, 0);
        check("single_count", count, 1);
        cycle();
        #1;
        check("single_count_after", count, 0);
        cycle();

        // ---------------- fairness ----------------
        gnt_obs.delete();
        out_obs.delete();
        for (int k = 0; k < 6; k++) begin
            gen(100);
            cycle();
        end
        flush();
        check("fair_ngnt", gnt_obs.size() >= 6, 1);
        check("fair_nout", out_obs.size() >= 6, 1);
        if (gnt_obs.size() >= 6 && out_obs.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                check("fair_gnt", gnt_obs[k], k % 2);
                check("fair_out_id", out_obs[k].id, k % 2);
            end
        end

        // ---------------- steady stream ----------------
        for (int k = 0; k < 10; k++) begin
            if (!req_valid[0]) begin
                req_valid[0] = 1'b1;
                req_data[0] = 8'(k);
            end
            if (k >= 3) begin
                #1;
                check("steady_count", count, 3);
            end
            cycle();
        end
        flush();

        // ---------------- backpressure ----------------
        out_obs.delete();
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            req_valid[0] = 1'b1;
            req_data[0] = 8'(8'h11 * (k + 1));
            cycle();
        end
        out_ready = 1'b0;
        gen(100);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_ready", req_ready, 2'b00);
            check("bp_count", count, 3);
            cycle();
        end
        flush();
        check("bp_nout", out_obs.size() >= 3, 1);
        if (out_obs.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check("bp_cycle", out_obs[k].cyc, c + k + DEPTH + 4);
                check("bp_data", out_obs[k].data, 8'h11 * (k + 1));
            end
        end

        // ---------------- drain ----------------
        out_obs.delete();
        for (int k = 0; k < 2; k++) begin
            req_valid[0] = 1'b1;
            req_data[0] = 8'(8'hC0 + k);
            cycle();
        end
        drain = 1'b1;
        gen(100);
        found = 1'b0;
        first_drained = -1;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            check("drain_block", req_ready, 2'b00);
            if (drained) begin
                found = 1'b1;
                first_drained = cyc;
            end
            cycle();
        end
        check("drain_seen", found, 1);
        check("drain_nout", out_obs.size(), 2);
        if (out_obs.size() == 2) check("drain_edge", first_drained, out_obs[1].cyc + 1);
        drain = 1'b0;
        #1;
        check("drain_resume", req_ready != 2'b00, 1);
        cycle();
        flush();

        // ---------------- reset mid-flight ----------------
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p]) begin
                    req_valid[p] = 1'b1;
                    req_data[p] = 8'(8'hE0 + 2 * k + p);
                end
            end
            cycle();
        end
        if (!rr_m) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p]) begin
                    req_valid[p] = 1'b1;
                    req_data[p] = 8'(8'hE8 + p);
                end
            end
            cycle();
        end
        #1;
        check("rst_pre_count", count, 3);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_data[0] = 8'h55;
        req_data[1] = 8'h66;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_idle", idle, 1);
        check("rst_mid_rr", req_ready, 2'b01);
        q.delete();
        rr_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_obs.delete();
        for (int k = 0; k < 8; k++) cycle();
        hits = 0;
        foreach (out_obs[i]) if (out_obs[i].data[7:4] == 4'hE) hits++;
        check("rst_discard", hits, 0);
        flush();

        // ---------------- randomized ----------------
        for (int k = 0; k < 400; k++) begin
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(99) < 5) drain = ~drain;
            gen(60);
            cycle();
        end
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
